csa_slice_sequencer: RTL and testbench
======================================

Name: csa_slice_sequencer

Overview:
- Multi-cycle controller that adds two WIDTH-bit operands using a single BLOCK-bit carry-select slice, one slice per clock, LSB slice first.
- Each cycle it computes the two candidate slice results (carry-in 0 and carry-in 1). A 2:1 select, driven by the registered inter-slice carry, picks one of them.
- Sits in the carry-select adder area as the sequencer that time-shares one slice datapath across a wide add.
- Uses a start/ready/done handshake toward the issuing logic.

Parameters:
- WIDTH, 32, operand and sum width in bits. Must be a multiple of BLOCK.
- BLOCK, 8, slice width in bits.
- NBLK, WIDTH/BLOCK, derived (localparam), number of slices. NBLK ≥ 1.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request to begin an add. Accepted only when ready=1.
- a  in  WIDTH  operand A. Sampled on the accepting edge only.
- b  in  WIDTH  operand B. Sampled on the accepting edge only.
- cin  in  1  carry into bit 0. Sampled on the accepting edge only.
- ready  out  1  high in IDLE. Decoded directly from state.
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse: result valid.
- slice_idx  out  max(1,$clog2(NBLK))  index of the slice being computed in RUN. 0 otherwise.
- sum  out  WIDTH  result register.
- cout  out  1  carry out of bit WIDTH-1.
- ovf  out  1  signed overflow = carry into MSB XOR cout.

Behaviour:
- Reset (rst=1 at an edge, overriding everything):
  - state=IDLE; sum=0, cout=0, ovf=0, done=0, slice_idx=0, carry register=0.
  - Outputs after reset: ready=1, busy=0.
- States: IDLE, RUN, DONE.
- IDLE:
  - ready=1.
  - On an edge with start=1: latch a, b → op regs; carry ← cin; idx ← 0; sum ← 0; cout ← 0; ovf ← 0; go to RUN.
  - start=0: remain in IDLE; sum/cout/ovf hold their last result.
- RUN:
  - Combinational, from the latched slice idx:
    - s0 = A[idx] + B[idx] + 0
    - s1 = A[idx] + B[idx] + 1
    - Each is BLOCK+1 bits; the MSB is the slice carry.
    - sel = carry. Selected = sel ? s1 : s0.
  - At each edge:
    - sum[idx*BLOCK +: BLOCK] ← selected[BLOCK-1:0].
    - carry ← selected[BLOCK].
    - idx ← idx+1.
  - When idx=NBLK-1 at the edge:
    - cout ← selected[BLOCK].
    - ovf ← selected[BLOCK] XOR (carry into the slice MSB, computed inside the selected candidate).
    - go to DONE.
- DONE:
  - done=1 for exactly one cycle; ready=0, busy=0.
  - Next edge → IDLE unconditionally.
- Latency:
  - Start accepted at edge t.
  - Slices written at edges t+1 … t+NBLK.
  - done is high between edges t+NBLK and t+NBLK+1.
  - Next accept is possible at edge t+NBLK+2 at the earliest. Throughput is one add per NBLK+2 cycles.
- start while in RUN or DONE: ignored. It is not queued; a, b, cin changes have no effect.
- sum is partially updated during RUN and is only valid while done=1 or in IDLE after a completed add. It holds until the next accept clears it.
- NBLK=1: RUN lasts one cycle. The idx register is tied to 0.
- rst in RUN or DONE: immediate return to IDLE with reset values. No done pulse is produced for the aborted add.
- Arithmetic is unsigned modulo 2^WIDTH. ovf is meaningful only for two's-complement interpretation.

Test Plan (WIDTH=32, BLOCK=8):
- Assert rst for 2 cycles → ready=1, busy=0, done=0, sum=0, cout=0, ovf=0, slice_idx=0.
- a=0xFFFFFFFF, b=0x00000001, cin=0, start at edge t → done high at edge t+4 for one cycle, sum=0x00000000, cout=1, ovf=0. busy high during edges t+1..t+4 and slice_idx steps 0,1,2,3.
- a=0x7FFFFFFF, b=0x00000001, cin=0 → sum=0x80000000, cout=0, ovf=1. Then a=0, b=0, cin=1 → sum=0x00000001, cout=0, ovf=0.
- Start held high continuously with a, b changing every cycle during RUN → only the operands sampled at the accepting edge are used. Accepts occur every 6 cycles; no done pulse is ever longer than 1 cycle.
- a=0x12345678, b=0x0F0F0F0F accepted at t, rst asserted at edge t+2 → IDLE, ready=1, sum=0, no done pulse. A new add started afterwards completes correctly: a=1, b=2 → sum=3.
- 1000 random (a, b, cin) with random start gaps → every sum/cout equals {cout,sum} = a+b+cin and ovf matches a signed-overflow model.

Source files
------------

// File: rtl/csa_slice_sequencer_if.sv
// Handshake and result bundle between the issuing logic (master) and the
// carry-select slice sequencer (slave).
interface csa_slice_sequencer_if #(
  parameter int WIDTH = 32,
  parameter int BLOCK = 8
);
  localparam int NBLK = WIDTH / BLOCK;
  localparam int IDXW = (NBLK > 1) ? $clog2(NBLK) : 1;

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             ready;
  logic             busy;
  logic             done;
  logic [IDXW-1:0]  slice_idx;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output start, a, b, cin,
    input  ready, busy, done, slice_idx, sum, cout, ovf
  );

  modport slave (
    input  start, a, b, cin,
    output ready, busy, done, slice_idx, sum, cout, ovf
  );
endinterface

// File: rtl/csa_slice_sequencer.sv
// Wide adder built by time-sharing one BLOCK-bit carry-select slice,
// LSB slice first, one slice per clock.
module csa_slice_sequencer #(
  parameter int WIDTH = 32,
  parameter int BLOCK = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  csa_slice_sequencer_if.slave  bus_if
);
  localparam int NBLK = WIDTH / BLOCK;
  localparam int IDXW = (NBLK > 1) ? $clog2(NBLK) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NBLK - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] opA_q, opA_d;
  logic [WIDTH-1:0] opB_q, opB_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic [IDXW-1:0]  idx_q, idx_d;

  int               sliceBase;
  logic [BLOCK-1:0] sliceA, sliceB;
  logic [BLOCK:0]   cand0, cand1, selected;
  logic             msbCarryIn;

  // Both carry-in candidates are formed every cycle; the registered carry picks one.
  always_comb begin
    sliceBase  = int'(idx_q) * BLOCK;
    sliceA     = opA_q[sliceBase +: BLOCK];
    sliceB     = opB_q[sliceBase +: BLOCK];
    cand0      = {1'b0, sliceA} + {1'b0, sliceB};
    cand1      = cand0 + (BLOCK+1)'(1);
    selected   = carry_q ? cand1 : cand0;
    msbCarryIn = sliceA[BLOCK-1] ^ sliceB[BLOCK-1] ^ selected[BLOCK-1];
  end

  always_comb begin
    state_d = state_q;
    opA_d   = opA_q;
    opB_d   = opB_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    idx_d   = idx_q;
    case (state_q)
      S_IDLE: begin
        if (bus_if.start) begin
          opA_d   = bus_if.a;
          opB_d   = bus_if.b;
          carry_d = bus_if.cin;
          idx_d   = '0;
          sum_d   = '0;
          cout_d  = 1'b0;
          ovf_d   = 1'b0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        sum_d[sliceBase +: BLOCK] = selected[BLOCK-1:0];
        carry_d = selected[BLOCK];
        if (idx_q == LAST_IDX) begin
          cout_d  = selected[BLOCK];
          ovf_d   = selected[BLOCK] ^ msbCarryIn;
          idx_d   = '0;
          state_d = S_DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      opA_q   <= '0;
      opB_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      opA_q   <= opA_d;
      opB_q   <= opB_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      idx_q   <= idx_d;
    end
  end

  assign bus_if.ready     = (state_q == S_IDLE);
  assign bus_if.busy      = (state_q == S_RUN);
  assign bus_if.done      = (state_q == S_DONE);
  assign bus_if.slice_idx = (state_q == S_RUN) ? idx_q : '0;
  assign bus_if.sum       = sum_q;
  assign bus_if.cout      = cout_q;
  assign bus_if.ovf       = ovf_q;
endmodule

// File: tb/tb_csa_slice_sequencer.sv
// Bench for csa_slice_sequencer: a timeline/arithmetic model predicts every
// output each cycle, plus directed literal cases and randomized adds.
module tb_csa_slice_sequencer;
  localparam int WIDTH = 32;
  localparam int BLOCK = 8;
  localparam int NBLK  = WIDTH / BLOCK;
  localparam int IDXW  = (NBLK > 1) ? $clog2(NBLK) : 1;

  logic clk = 1'b0;
  logic rst;

  csa_slice_sequencer_if #(.WIDTH(WIDTH), .BLOCK(BLOCK)) bus ();

  csa_slice_sequencer #(.WIDTH(WIDTH), .BLOCK(BLOCK)) dut (
    .clk_i  (clk),
    .rst_i  (rst),
    .bus_if (bus.slave)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int doneSeen = 0;

  // Model: phase 0 = idle, 1..NBLK = computing slice phase-1, NBLK+1 = done.
  int               phase = 0;
  int               cycle = 0;
  bit               modelValid = 1'b0;
  logic [WIDTH+1:0] pendRes = '0;
  logic [WIDTH+1:0] expRes = '0;
  int               acceptCycles[$];

  // Returns {ovf, cout, sum} from plain wide arithmetic and sign rules.
  function automatic logic [WIDTH+1:0] modelAdd(input logic [WIDTH-1:0] x,
                                                input logic [WIDTH-1:0] y,
                                                input logic c);
    logic [WIDTH:0] full;
    logic           v;
    full = {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, c};
    v = (x[WIDTH-1] == y[WIDTH-1]) && (full[WIDTH-1] != x[WIDTH-1]);
    return {v, full};
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at time %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    cycle <= cycle + 1;
    if (rst) begin
      phase      <= 0;
      expRes     <= '0;
      modelValid <= 1'b1;
    end else if (modelValid) begin
      if (phase == 0) begin
        if (bus.start) begin
          pendRes <= modelAdd(bus.a, bus.b, bus.cin);
          acceptCycles.push_back(cycle);
          phase <= 1;
        end
      end else if (phase < NBLK) begin
        phase <= phase + 1;
      end else if (phase == NBLK) begin
        phase  <= NBLK + 1;
        expRes <= pendRes;
      end else begin
        phase <= 0;
      end
    end
  end

  always @(negedge clk) begin
    if (modelValid) begin
      logic           expBusy;
      logic [IDXW-1:0] expIdx;
      expBusy = (phase >= 1) && (phase <= NBLK);
      expIdx  = expBusy ? IDXW'(phase - 1) : '0;
      if (bus.done === 1'b1) doneSeen++;
      checkOutput("ready", bus.ready, phase == 0);
      checkOutput("busy", bus.busy, expBusy);
      checkOutput("done", bus.done, phase == NBLK + 1);
      checkOutput("slice_idx", bus.slice_idx, expIdx);
      if (phase == 0 || phase == NBLK + 1) begin
        checkOutput("sum", bus.sum, expRes[WIDTH-1:0]);
        checkOutput("cout", bus.cout, expRes[WIDTH]);
        checkOutput("ovf", bus.ovf, expRes[WIDTH+1]);
      end
    end
  end

  task automatic applyStimulus(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                               input logic c, input int gap);
    int n;
    repeat (gap) @(negedge clk);
    n = 0;
    while (bus.ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (bus.ready !== 1'b1) checkOutput("readyTimeout", bus.ready, 1);
    bus.start = 1'b1;
    bus.a     = x;
    bus.b     = y;
    bus.cin   = c;
    @(negedge clk);
    bus.start = 1'b0;
    bus.a     = $urandom;
    bus.b     = $urandom;
    bus.cin   = 1'($urandom_range(0, 1));
  endtask

  task automatic waitDone(output int n);
    n = 0;
    while (bus.done !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (bus.done !== 1'b1) checkOutput("doneTimeout", bus.done, 1);
  endtask

  task automatic runAdd(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input logic c,
                        input logic [WIDTH-1:0] es, input logic ec, input logic eo);
    int lat;
    applyStimulus(x, y, c, 0);
    waitDone(lat);
    checkOutput("latency", lat, 4);
    checkOutput("litSum", bus.sum, es);
    checkOutput("litCout", bus.cout, ec);
    checkOutput("litOvf", bus.ovf, eo);
  endtask

  initial begin
    int lat;
    int doneBefore;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    bus.cin   = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("rstReady", bus.ready, 1);
    checkOutput("rstBusy", bus.busy, 0);
    checkOutput("rstDone", bus.done, 0);
    checkOutput("rstSum", bus.sum, 0);
    checkOutput("rstCout", bus.cout, 0);
    checkOutput("rstOvf", bus.ovf, 0);
    checkOutput("rstIdx", bus.slice_idx, 0);
    rst = 1'b0;
    @(negedge clk);

    runAdd(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
    runAdd(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
    runAdd(32'h0000_0000, 32'h0000_0000, 1'b1, 32'h0000_0001, 1'b0, 1'b0);
    runAdd(32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1);

    // Start held high with operands churning every cycle.
    applyStimulus(32'h0, 32'h0, 1'b0, 2);
    waitDone(lat);
    @(negedge clk);
    acceptCycles.delete();
    bus.start = 1'b1;
    for (int i = 0; i < 20; i++) begin
      bus.a   = $urandom;
      bus.b   = $urandom;
      bus.cin = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    bus.start = 1'b0;
    checkOutput("acceptCount", acceptCycles.size(), 4);
    for (int i = 1; i < acceptCycles.size(); i++)
      checkOutput("acceptGap", acceptCycles[i] - acceptCycles[i-1], NBLK + 2);
    waitDone(lat);
    @(negedge clk);

    // Abort an add with reset two edges after acceptance.
    applyStimulus(32'h1234_5678, 32'h0F0F_0F0F, 1'b0, 0);
    doneBefore = doneSeen;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    checkOutput("abortNoDone", doneSeen, doneBefore);
    checkOutput("abortReady", bus.ready, 1);
    checkOutput("abortSum", bus.sum, 0);
    runAdd(32'd1, 32'd2, 1'b0, 32'd3, 1'b0, 1'b0);

    for (int i = 0; i < 1000; i++) begin
      applyStimulus($urandom, $urandom, 1'($urandom_range(0, 1)), $urandom_range(0, 3));
      waitDone(lat);
    end
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
